// File: rtl/bcd_pkg.sv
// Shared constants, FSM encoding and digit helper for the BCD conversion scheduler.
package bcd_pkg;

    localparam int NUM_DIGITS = 10;
    localparam int BIN_W      = 34;
    localparam int BATCH_LEN  = 300;
    localparam int CNT_W      = 9;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        DONE = 2'd2,
        HOLD = 2'd3
    } state_t;

    function automatic logic nibble_invalid(input logic [3:0] nib);
        return nib > 4'd9;
    endfunction

endpackage

// File: rtl/bcd_serial_conv.sv
// Serial BCD-to-binary engine: holds one word and folds in one digit per step, MSD first.
module bcd_serial_conv #(
    parameter int NUM_DIGITS = bcd_pkg::NUM_DIGITS,
    parameter int BIN_W      = bcd_pkg::BIN_W
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    load_i,
    input  logic                    step_i,
    input  logic [4*NUM_DIGITS-1:0] word_i,
    output logic [BIN_W-1:0]        acc_o,
    output logic                    last_o,
    output logic                    err_o
);
    import bcd_pkg::*;

    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    logic [4*NUM_DIGITS-1:0] word_q, word_d;
    logic [BIN_W-1:0]        acc_q, acc_d, acc_step;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic                    err_q, err_d;
    logic                    word_bad;
    logic [3:0]              nib;

    always_comb begin
        word_bad = 1'b0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (nibble_invalid(word_i[4*i +: 4])) word_bad = 1'b1;
        end
    end

    assign nib = word_q[4*idx_q +: 4];

    // acc*10 as shift-and-add; the final value always fits in BIN_W.
    assign acc_step = (acc_q << 3) + (acc_q << 1) + BIN_W'(nib);

    always_comb begin
        word_d = word_q;
        acc_d  = acc_q;
        idx_d  = idx_q;
        err_d  = err_q;
        if (load_i) begin
            word_d = word_i;
            acc_d  = '0;
            idx_d  = IDX_W'(NUM_DIGITS - 1);
            err_d  = word_bad;
        end else if (step_i) begin
            acc_d = acc_step;
            idx_d = idx_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            word_q <= '0;
            acc_q  <= '0;
            idx_q  <= '0;
            err_q  <= 1'b0;
        end else begin
            word_q <= word_d;
            acc_q  <= acc_d;
            idx_q  <= idx_d;
            err_q  <= err_d;
        end
    end

    // acc_o already includes the digit being stepped this cycle.
    assign acc_o  = acc_step;
    assign last_o = (idx_q == '0);
    assign err_o  = err_q;

endmodule

// File: rtl/bcd_conv_scheduler.sv
// Round-robin scheduler sharing one serial BCD converter between two requesters, with batch counting.
module bcd_conv_scheduler #(
    parameter int NUM_DIGITS = bcd_pkg::NUM_DIGITS,
    parameter int BIN_W      = bcd_pkg::BIN_W,
    parameter int BATCH_LEN  = bcd_pkg::BATCH_LEN,
    parameter int CNT_W      = bcd_pkg::CNT_W
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [1:0]              req_valid,
    input  logic [4*NUM_DIGITS-1:0] req_bcd0,
    input  logic [4*NUM_DIGITS-1:0] req_bcd1,
    output logic [1:0]              req_ready,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [BIN_W-1:0]        out_bin,
    output logic                    out_id,
    output logic                    out_err,
    output logic [CNT_W-1:0]        batch_cnt,
    output logic [CNT_W-1:0]        err_cnt,
    output logic                    batch_done,
    input  logic                    batch_start,
    output logic [1:0]              dbg_state_o
);
    import bcd_pkg::*;

    state_t                  state_q, state_d;
    logic                    rr_q, rr_d;
    logic                    id_q, id_d;
    logic                    out_valid_q, out_valid_d;
    logic [BIN_W-1:0]        out_bin_q, out_bin_d;
    logic                    out_id_q, out_id_d;
    logic                    out_err_q, out_err_d;
    logic [CNT_W-1:0]        batch_cnt_q, batch_cnt_d;
    logic [CNT_W-1:0]        err_cnt_q, err_cnt_d;
    logic                    batch_done_q, batch_done_d;

    logic [1:0]              grant;
    logic                    accept, grant_id;
    logic [4*NUM_DIGITS-1:0] word_sel;
    logic                    load, step;
    logic [BIN_W-1:0]        conv_acc;
    logic                    conv_last, conv_err;
    logic [CNT_W-1:0]        batch_inc;

    // Valid/ready: a word transfers on any rising edge where req_valid[i] and req_ready[i]
    // are both high; a result transfers on any edge where out_valid and out_ready are high.
    always_comb begin
        grant = 2'b00;
        if (state_q == IDLE && !reset) begin
            if (req_valid[rr_q])       grant[rr_q]  = 1'b1;
            else if (req_valid[~rr_q]) grant[~rr_q] = 1'b1;
        end
    end

    assign accept   = |(req_valid & grant);
    assign grant_id = grant[1];
    assign word_sel = grant_id ? req_bcd1 : req_bcd0;
    assign batch_inc = batch_cnt_q + 1'b1;

    bcd_serial_conv #(
        .NUM_DIGITS (NUM_DIGITS),
        .BIN_W      (BIN_W)
    ) u_conv (
        .clk    (clk),
        .reset  (reset),
        .load_i (load),
        .step_i (step),
        .word_i (word_sel),
        .acc_o  (conv_acc),
        .last_o (conv_last),
        .err_o  (conv_err)
    );

    always_comb begin
        state_d      = state_q;
        rr_d         = rr_q;
        id_d         = id_q;
        out_valid_d  = out_valid_q;
        out_bin_d    = out_bin_q;
        out_id_d     = out_id_q;
        out_err_d    = out_err_q;
        batch_cnt_d  = batch_cnt_q;
        err_cnt_d    = err_cnt_q;
        batch_done_d = 1'b0;
        load         = 1'b0;
        step         = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    load    = 1'b1;
                    id_d    = grant_id;
                    rr_d    = ~grant_id;
                    state_d = CONV;
                end
            end
            CONV: begin
                step = 1'b1;
                if (conv_last) begin
                    out_valid_d = 1'b1;
                    out_bin_d   = conv_err ? '0 : conv_acc;
                    out_id_d    = id_q;
                    out_err_d   = conv_err;
                    state_d     = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    batch_cnt_d = batch_inc;
                    if (out_err_q && err_cnt_q != {CNT_W{1'b1}}) err_cnt_d = err_cnt_q + 1'b1;
                    if (batch_inc == CNT_W'(BATCH_LEN)) begin
                        batch_done_d = 1'b1;
                        state_d      = HOLD;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            HOLD: begin
                if (batch_start) begin
                    batch_cnt_d = '0;
                    err_cnt_d   = '0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            rr_q         <= 1'b0;
            id_q         <= 1'b0;
            out_valid_q  <= 1'b0;
            out_bin_q    <= '0;
            out_id_q     <= 1'b0;
            out_err_q    <= 1'b0;
            batch_cnt_q  <= '0;
            err_cnt_q    <= '0;
            batch_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            rr_q         <= rr_d;
            id_q         <= id_d;
            out_valid_q  <= out_valid_d;
            out_bin_q    <= out_bin_d;
            out_id_q     <= out_id_d;
            out_err_q    <= out_err_d;
            batch_cnt_q  <= batch_cnt_d;
            err_cnt_q    <= err_cnt_d;
            batch_done_q <= batch_done_d;
        end
    end

    assign req_ready   = grant;
    assign out_valid   = out_valid_q;
    assign out_bin     = out_bin_q;
    assign out_id      = out_id_q;
    assign out_err     = out_err_q;
    assign batch_cnt   = batch_cnt_q;
    assign err_cnt     = err_cnt_q;
    assign batch_done  = batch_done_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_bcd_conv_scheduler.sv
// Randomized scoreboard bench for bcd_conv_scheduler with a digit-arithmetic reference model.
module tb_bcd_conv_scheduler;

    localparam int ND = 10;
    localparam int BW = 34;
    localparam int BL = 300;
    localparam int CW = 9;
    localparam int WW = 4 * ND;
    localparam int EW = BW + 2;

    logic          clk = 1'b0;
    logic          reset;
    logic [1:0]    req_valid;
    logic [WW-1:0] req_bcd0, req_bcd1;
    logic [1:0]    req_ready;
    logic          out_valid, out_ready;
    logic [BW-1:0] out_bin;
    logic          out_id, out_err;
    logic [CW-1:0] batch_cnt, err_cnt;
    logic          batch_done, batch_start;
    logic [1:0]    dbg_state;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    logic [EW-1:0] exp_q[$];
    int            acc_cyc_q[$];
    bit            rr_exp, hold_exp, done_exp, prev_valid, prev_stall;
    logic [EW-1:0] held;
    int            model_batch, model_err;

    bcd_conv_scheduler dut (
        .clk         (clk),
        .reset       (reset),
        .req_valid   (req_valid),
        .req_bcd0    (req_bcd0),
        .req_bcd1    (req_bcd1),
        .req_ready   (req_ready),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_bin     (out_bin),
        .out_id      (out_id),
        .out_err     (out_err),
        .batch_cnt   (batch_cnt),
        .err_cnt     (err_cnt),
        .batch_done  (batch_done),
        .batch_start (batch_start),
        .dbg_state_o (dbg_state)
    );

    // Clock and reset-independent cycle counter.
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input bit ok, input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: decimal value of the digits, MSD first; any digit above 9 flags an error.
    function automatic logic [BW:0] ref_conv(input logic [WW-1:0] w);
        longint unsigned v;
        bit              e;
        int              n;
        v = 0;
        e = 0;
        for (int d = ND - 1; d >= 0; d--) begin
            n = int'(w[4*d +: 4]);
            if (n > 9) e = 1;
            v = v * 10 + longint'(n);
        end
        if (e) return {1'b1, {BW{1'b0}}};
        return {1'b0, BW'(v)};
    endfunction

    function automatic logic [WW-1:0] rand_word(input bit allow_bad);
        logic [WW-1:0] w;
        int            p;
        for (int d = 0; d < ND; d++) w[4*d +: 4] = 4'($urandom_range(0, 9));
        if (allow_bad && $urandom_range(0, 3) == 0) begin
            p = $urandom_range(0, ND - 1);
            w[4*p +: 4] = 4'($urandom_range(10, 15));
        end
        return w;
    endfunction

    // Monitor and scoreboard: samples on the falling edge, mid-cycle.
    always @(negedge clk) begin
        bit            busy, hold_was, id;
        logic [1:0]    g_exp, acc;
        logic [EW-1:0] got;
        logic [BW:0]   r;
        if (reset) begin
            exp_q.delete();
            acc_cyc_q.delete();
            rr_exp      = 0;
            hold_exp    = 0;
            done_exp    = 0;
            prev_valid  = 0;
            prev_stall  = 0;
            model_batch = 0;
            model_err   = 0;
        end else begin
            busy     = (exp_q.size() != 0) || hold_exp;
            hold_was = hold_exp;
            chk(batch_done === done_exp, "batch_done", 64'(batch_done), 64'(done_exp));
            if (done_exp) chk(batch_cnt === CW'(BL), "batch_cnt_final", 64'(batch_cnt), 64'(BL));
            done_exp = 0;
            got = {out_id, out_err, out_bin};
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    chk(0, "unexpected_out", 64'(got), 64'(0));
                end else begin
                    if (!prev_valid) chk(cyc - acc_cyc_q[0] == ND, "latency", 64'(cyc - acc_cyc_q[0]), 64'(ND));
                    if (prev_valid && prev_stall) chk(got === held, "stall_hold", 64'(got), 64'(held));
                    if (out_ready) begin
                        chk(got === exp_q[0], "result", 64'(got), 64'(exp_q[0]));
                        chk(batch_cnt === CW'(model_batch), "batch_cnt", 64'(batch_cnt), 64'(model_batch));
                        chk(err_cnt === CW'(model_err), "err_cnt", 64'(err_cnt), 64'(model_err));
                        if (exp_q[0][BW] && model_err < (1 << CW) - 1) model_err++;
                        model_batch++;
                        void'(exp_q.pop_front());
                        void'(acc_cyc_q.pop_front());
                        if (model_batch == BL) begin
                            hold_exp = 1;
                            done_exp = 1;
                        end
                    end
                end
                held = got;
            end
            prev_stall = out_valid && !out_ready;
            prev_valid = out_valid;
            if (busy) begin
                chk(req_ready === 2'b00, "ready_busy", 64'(req_ready), 64'(0));
            end else begin
                g_exp = 2'b00;
                if (req_valid[rr_exp])       g_exp[rr_exp]  = 1'b1;
                else if (req_valid[!rr_exp]) g_exp[!rr_exp] = 1'b1;
                chk(req_ready === g_exp, "grant", 64'(req_ready), 64'(g_exp));
                acc = req_valid & req_ready;
                if (acc == 2'b01 || acc == 2'b10) begin
                    id = acc[1];
                    r  = ref_conv(id ? req_bcd1 : req_bcd0);
                    exp_q.push_back({id, r});
                    acc_cyc_q.push_back(cyc + 1);
                    rr_exp = !id;
                end
            end
            if (hold_was && batch_start) begin
                hold_exp    = 0;
                model_batch = 0;
                model_err   = 0;
            end
        end
    end

    task automatic cyc_wait();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input int r, input logic [WW-1:0] w);
        int t;
        t = 0;
        req_valid = 2'b00;
        if (r == 0) req_bcd0 = w;
        else        req_bcd1 = w;
        req_valid[r] = 1'b1;
        do begin
            @(negedge clk);
            t++;
        end while (!req_ready[r] && t < 100);
        if (t >= 100) chk(0, "accept_timeout", 64'(t), 64'(0));
        cyc_wait();
        req_valid[r] = 1'b0;
    endtask

    task automatic drain();
        int t;
        t = 0;
        while (exp_q.size() != 0 && t < 300) begin
            cyc_wait();
            t++;
        end
        if (t >= 300) chk(0, "drain_timeout", 64'(exp_q.size()), 64'(0));
        cyc_wait();
    endtask

    initial begin
        int t;
        reset       = 1'b1;
        req_valid   = 2'b11;
        req_bcd0    = '0;
        req_bcd1    = '0;
        out_ready   = 1'b1;
        batch_start = 1'b0;

        // Reset with both requesters valid.
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk({req_ready, out_valid, out_bin, out_id, out_err, batch_cnt, err_cnt, batch_done, dbg_state} === '0,
            "reset_outputs", 64'({req_ready, out_valid, out_id, out_err, batch_done, dbg_state}), 64'(0));
        chk(out_bin === '0, "reset_out_bin", 64'(out_bin), 64'(0));
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk(req_ready === 2'b01, "first_grant", 64'(req_ready), 64'(1));
        cyc_wait();
        req_valid = 2'b00;
        drain();

        // Directed words.
        send(0, 40'h0000000123);
        drain();
        send(1, 40'h9999999999);
        drain();
        send(0, 40'h00000000A5);
        drain();
        chk(err_cnt === CW'(1), "err_cnt_after_bad", 64'(err_cnt), 64'(1));
        chk(batch_cnt === CW'(model_batch), "batch_cnt_directed", 64'(batch_cnt), 64'(model_batch));

        // Both requesters continuously valid, then a 5-cycle consumer stall.
        req_valid = 2'b11;
        repeat (8 * (ND + 2)) begin
            req_bcd0 = rand_word(0);
            req_bcd1 = rand_word(0);
            cyc_wait();
        end
        out_ready = 1'b0;
        t = 0;
        while (!out_valid && t < 40) begin
            cyc_wait();
            t++;
        end
        if (t >= 40) chk(0, "stall_wait_timeout", 64'(t), 64'(0));
        repeat (5) cyc_wait();
        out_ready = 1'b1;
        req_valid = 2'b00;
        drain();

        // Random traffic until the batch completes; batch_start is held high outside HOLD.
        t = 0;
        while (t < 30000) begin
            cyc_wait();
            t++;
            if (hold_exp) begin
                batch_start = 1'b0;
                break;
            end
            req_valid   = 2'($urandom_range(0, 3));
            req_bcd0    = rand_word(1);
            req_bcd1    = rand_word(1);
            out_ready   = ($urandom_range(0, 3) != 0);
            batch_start = 1'b1;
        end
        if (!hold_exp) chk(0, "hold_timeout", 64'(model_batch), 64'(BL));
        batch_start = 1'b0;
        req_valid   = 2'b11;
        out_ready   = 1'b1;
        repeat (20) cyc_wait();
        chk(batch_cnt === CW'(BL), "batch_cnt_hold", 64'(batch_cnt), 64'(BL));
        req_valid   = 2'b00;
        batch_start = 1'b1;
        cyc_wait();
        batch_start = 1'b0;
        chk({batch_cnt, err_cnt} === '0, "counters_cleared", 64'({batch_cnt, err_cnt}), 64'(0));
        send(1, rand_word(1));
        drain();
        send(0, rand_word(1));
        drain();

        // Reset in the middle of a conversion.
        send(0, 40'h0000004567);
        repeat (3) cyc_wait();
        reset = 1'b1;
        repeat (2) cyc_wait();
        chk(out_valid === 1'b0, "reset_mid_valid", 64'(out_valid), 64'(0));
        reset = 1'b0;
        repeat (20) cyc_wait();
        chk(out_valid === 1'b0, "no_out_after_abort", 64'(out_valid), 64'(0));
        send(1, 40'h0000000042);
        drain();
        chk(batch_cnt === CW'(1), "batch_cnt_after_reset", 64'(batch_cnt), 64'(1));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog actual=%0d required=finish", cyc);
        $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
        $fatal(1);
    end

endmodule
